// File: rtl/sad_hardware.sv
// Frame locator: serial binary image in, bounding-box centre out.
// One 640x480 frame of 8-pixel bytes, 10 clocks per byte.
module sad_hardware (
  input  logic       clock,
  input  logic       notReset,
  input  logic       RxD,
  output logic       valid,
  output logic [9:0] x_out,
  output logic [8:0] y_out
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    RESYNC
  } rx_state_t;

  rx_state_t   state;
  rx_state_t   state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  data_q;
  logic        acc;
  logic        accept;

  logic [6:0]  col;
  logic [8:0]  row;
  logic        eof;
  logic        empty;
  logic [9:0]  min_x;
  logic [9:0]  max_x;
  logic [8:0]  min_y;
  logic [8:0]  max_y;

  logic [2:0]  lo;
  logic [2:0]  hi;
  logic [9:0]  x_lo;
  logic [9:0]  x_hi;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;
  logic        last;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (!RxD) state_nxt = DATA;
      DATA:   if (bit_cnt == 3'd7) state_nxt = STOP;
      STOP:   state_nxt = RxD ? IDLE : RESYNC;
      RESYNC: if (RxD) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == STOP) && RxD;

  // First bit in time ends up in shift[0] (leftmost pixel).
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      acc     <= 1'b0;
    end else begin
      acc <= accept;
      if (state == DATA) begin
        shift   <= {RxD, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else begin
        bit_cnt <= '0;
      end
      if (accept) data_q <= shift;
    end
  end

  always_comb begin
    lo = '0;
    hi = '0;
    for (int i = 7; i >= 0; i--)
      if (data_q[i]) lo = i[2:0];
    for (int i = 0; i < 8; i++)
      if (data_q[i]) hi = i[2:0];
  end

  assign x_lo  = {col, lo};
  assign x_hi  = {col, hi};
  assign sum_x = {1'b0, min_x} + {1'b0, max_x};
  assign sum_y = {1'b0, min_y} + {1'b0, max_y};
  assign last  = (col == 7'd79) && (row == 9'd479);

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      col   <= '0;
      row   <= '0;
      eof   <= 1'b0;
      empty <= 1'b1;
      min_x <= 10'd639;
      max_x <= '0;
      min_y <= 9'd479;
      max_y <= '0;
      valid <= 1'b0;
      x_out <= '0;
      y_out <= '0;
    end else begin
      valid <= 1'b0;
      eof   <= 1'b0;
      if (eof) begin
        valid <= 1'b1;
        x_out <= empty ? 10'd0 : sum_x[10:1];
        y_out <= empty ? 9'd0 : sum_y[9:1];
        empty <= 1'b1;
        min_x <= 10'd639;
        max_x <= '0;
        min_y <= 9'd479;
        max_y <= '0;
      end else if (acc) begin
        if (|data_q) begin
          empty <= 1'b0;
          if (x_lo < min_x) min_x <= x_lo;
          if (x_hi > max_x) max_x <= x_hi;
          if (row < min_y)  min_y <= row;
          if (row > max_y)  max_y <= row;
        end
        eof <= last;
        if (col == 7'd79) begin
          col <= '0;
          row <= (row == 9'd479) ? 9'd0 : row + 9'd1;
        end else begin
          col <= col + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_hardware.sv
// Bench for sad_hardware: frame table plus reset/error sequences.
// Expected centres queued at the last stop bit, checked on valid.
module tb_sad_hardware;

  logic       clock;
  logic       notReset;
  logic       RxD;
  logic       valid;
  logic [9:0] x_out;
  logic [8:0] y_out;

  sad_hardware dut (
    .clock    (clock),
    .notReset (notReset),
    .RxD      (RxD),
    .valid    (valid),
    .x_out    (x_out),
    .y_out    (y_out)
  );

  typedef struct {
    int npix;
    int px0;
    int py0;
    int px1;
    int py1;
    int err_byte;
    int ex;
    int ey;
  } vec_t;

  typedef struct {
    int x;
    int y;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   n_valid;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (valid) begin
      exp_t e;
      n_valid++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("x_out", int'(x_out), e.x);
        chk("y_out", int'(y_out), e.y);
        chk("valid_cycle", cyc, e.due);
      end
    end
  end

  // Returns the cycle index of the edge that samples the stop bit.
  task automatic send_byte(input logic [7:0] b, input bit bad,
                           output int stop_edge);
    @(negedge clock) RxD = 1'b0;
    for (int i = 0; i < 8; i++)
      @(negedge clock) RxD = b[i];
    @(negedge clock) RxD = bad ? 1'b0 : 1'b1;
    stop_edge = cyc + 1;
  endtask

  function automatic logic [7:0] byte_val(input vec_t v, input int idx);
    logic [7:0] b;
    int r;
    int c;
    b = '0;
    r = idx / 80;
    c = idx % 80;
    if (v.npix > 0 && v.py0 == r && v.px0 / 8 == c) b[v.px0 % 8] = 1'b1;
    if (v.npix > 1 && v.py1 == r && v.px1 / 8 == c) b[v.px1 % 8] = 1'b1;
    return b;
  endfunction

  task automatic send_frame(input vec_t v);
    int se;
    exp_t e;
    se = 0;
    for (int idx = 0; idx < 38400; idx++) begin
      if (idx == v.err_byte) begin
        send_byte(8'hFF, 1'b1, se);
        @(negedge clock) RxD = 1'b1;
      end
      send_byte(byte_val(v, idx), 1'b0, se);
    end
    e.x   = v.ex;
    e.y   = v.ey;
    e.due = se + 2;
    q.push_back(e);
  endtask

  vec_t tbl[3];
  vec_t v10;
  int   se;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    n_valid = 0;
    cyc     = 0;
    RxD     = 1'b1;
    notReset = 1'b0;

    tbl[0] = '{npix: 1, px0: 100, py0: 200, px1: 0, py1: 0,
               err_byte: 5, ex: 100, ey: 200};
    tbl[1] = '{npix: 2, px0: 0, py0: 0, px1: 639, py1: 479,
               err_byte: -1, ex: 319, ey: 239};
    tbl[2] = '{npix: 0, px0: 0, py0: 0, px1: 0, py1: 0,
               err_byte: -1, ex: 0, ey: 0};
    v10    = '{npix: 1, px0: 10, py0: 10, px1: 0, py1: 0,
               err_byte: -1, ex: 10, ey: 10};

    repeat (3) @(negedge clock);
    chk("rst_valid", int'(valid), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    notReset = 1'b1;

    repeat (1000) @(negedge clock);
    chk("idle_valid_count", n_valid, 0);
    chk("idle_x", int'(x_out), 0);
    chk("idle_y", int'(y_out), 0);

    send_frame(tbl[0]);
    repeat (5) @(negedge clock);
    chk("err_frame_pending", q.size(), 0);

    for (int i = 0; i < 1000; i++)
      send_byte(8'h81, 1'b0, se);
    @(negedge clock);
    notReset = 1'b0;
    #1;
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_x", int'(x_out), 0);
    chk("midrst_y", int'(y_out), 0);
    repeat (2) @(negedge clock);
    notReset = 1'b1;
    RxD = 1'b1;
    send_frame(v10);

    for (int i = 1; i < 3; i++)
      send_frame(tbl[i]);

    for (int k = 0; k < 20 && q.size() != 0; k++)
      @(negedge clock);
    chk("pending_results", q.size(), 0);
    repeat (5) @(negedge clock);
    chk("valid_pulses", n_valid, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
